gt_link_bringup_seq: RTL and testbench
======================================

// Module: gt_link_bringup_seq
// PURPOSE
//  Parametrised bring-up sequencer for an N-lane GT/QSFP link in the shell. Drives the GT system reset,
//  waits for PLL lock and all-lane alignment, debounces, then releases the application reset.
//  Detects link loss, re-sequences with bounded retries, and reports status.
//  Sits between the GT core (or Aurora/MAC wrapper) and the user-side reset tree in shellTop.
// PARAMETERS
//  NUM_LANES          4       lanes monitored (1..16)
//  RESET_HOLD_CYCLES  64      cycles gt_sys_reset is held high per attempt (>=1)
//  LOCK_TIMEOUT       65536   max cycles in WAIT_LOCK before retry (>=1)
//  ALIGN_TIMEOUT      131072  max cycles in WAIT_ALIGN before retry (>=1)
//  DEBOUNCE_CYCLES    256     consecutive all-aligned cycles required for LINK_UP (>=1)
//  MAX_RETRIES        8       failed attempts before FAILED; 0 = retry forever
// PORTS
//  CLK            in   1          free-running init/system clock
//  rstn           in   1          async active-low reset
//  gt_pll_lock    in   1          GT PLL lock, async to CLK
//  lane_aligned   in   NUM_LANES  per-lane alignment/block-lock, async to CLK
//  gt_sys_reset   out  1          active-high reset to GT core
//  link_up        out  1          link established and debounced
//  user_rstn      out  1          active-low reset to application logic
//  link_fail      out  1          sticky; MAX_RETRIES exhausted
//  retry_count    out  8          failed attempts, saturates at 255
//  seq_state      out  3          current FSM state encoding
//  drop_count     out  16         link-drop events (LINK_STATS_EN only)
//  lane_drop_mask out  NUM_LANES  sticky lanes seen low during LINK_UP (LINK_STATS_EN only)
// BEHAVIOUR
//  - gt_pll_lock, lane_aligned: each through a 2-FF synchroniser; all FSM decisions use synced values (+2 cycles latency).
//  - Reset (rstn=0, async): state=RESET, all counters 0, gt_sys_reset=1, link_up=0, user_rstn=0,
//    link_fail=0, retry_count=0, drop_count=0, lane_drop_mask=0. All outputs registered.
//  - States/encoding: RESET=0, WAIT_LOCK=1, WAIT_ALIGN=2, DEBOUNCE=3, LINK_UP=4, FAILED=5.
//  - RESET: gt_sys_reset=1 for exactly RESET_HOLD_CYCLES cycles, then -> WAIT_LOCK (gt_sys_reset=0 from that cycle).
//  - WAIT_LOCK: synced lock=1 -> WAIT_ALIGN; timer reaches LOCK_TIMEOUT -> retry.
//  - WAIT_ALIGN: all synced lanes=1 -> DEBOUNCE; lock lost -> retry immediately; timer reaches ALIGN_TIMEOUT -> retry.
//  - DEBOUNCE: counts consecutive cycles with lock=1 and all lanes=1; any lane=0 -> back to WAIT_ALIGN
//    (ALIGN timer keeps running, not restarted); lock=0 -> retry; count reaches DEBOUNCE_CYCLES -> LINK_UP.
//  - LINK_UP: link_up=1, user_rstn=1 registered (high 1 cycle after state enters LINK_UP).
//    Any lane=0 or lock=0 -> RESET (link drop, NOT counted as a retry); link_up/user_rstn low next cycle; retry_count unchanged.
//  - Retry: retry_count+=1 (saturating 255); if MAX_RETRIES!=0 and new count==MAX_RETRIES -> FAILED, else -> RESET.
//  - FAILED: gt_sys_reset=1, link_up=0, user_rstn=0, link_fail=1; terminal until rstn.
//  - retry_count clears only on rstn; successful LINK_UP does not clear it.
//  - Timers are sized by $clog2 of their max parameter; no wrap-around (compare with >=, counter stops).
//  - Simultaneous lock loss and timeout in same cycle: single retry increment.
// CONFIGURATION
//  - `define GT_LINK_SEQ_STATS_EN: drop_count increments (saturating 0xFFFF) on each LINK_UP->RESET drop;
//    lane_drop_mask[i] set sticky when lane i synced low causes/accompanies a drop; both clear on rstn.
//  - Without macro: drop_count and lane_drop_mask driven constant 0; no stats registers synthesised.
// TESTING  (bench params: NUM_LANES=4, RESET_HOLD=4, LOCK_TO=16, ALIGN_TO=32, DEBOUNCE=8, MAX_RETRIES=2)
//  - Nominal: lock=1, lanes=4'hF from release -> gt_sys_reset high exactly 4 cycles; link_up=1 after
//    DEBOUNCE completes (+2 sync); user_rstn rises 1 cycle after seq_state=4; retry_count=0.
//  - Lock never asserts -> 16-cycle timeout, retry_count=1, RESET again; second timeout -> seq_state=5,
//    link_fail=1, gt_sys_reset=1, retry_count=2.
//  - Debounce glitch: lanes=4'hF, drop lane 2 for 1 cycle at debounce count 5 -> back to WAIT_ALIGN,
//    full 8 cycles needed again; no retry increment.
//  - Link drop: in LINK_UP, lanes=4'hB -> link_up/user_rstn low next cycle, seq_state=0, retry_count
//    unchanged; with GT_LINK_SEQ_STATS_EN drop_count=1, lane_drop_mask=4'h4; without, both 0.
//  - Async reset mid-DEBOUNCE: rstn low 1 cycle -> all outputs to reset values immediately, sequence restarts.
//  - MAX_RETRIES=0 with lock stuck low for 300 attempts -> never FAILED, retry_count saturates at 255.

Source files
------------

// File: rtl/gt_link_bringup_seq_if.sv
// gt_link_bringup_seq_if: GT-side and status signals of the link bring-up sequencer.
interface gt_link_bringup_seq_if #(parameter int NUM_LANES = 4);
    logic                 gt_pll_lock;
    logic [NUM_LANES-1:0] lane_aligned;
    logic                 gt_sys_reset;
    logic                 link_up;
    logic                 user_rstn;
    logic                 link_fail;
    logic [7:0]           retry_count;
    logic [2:0]           seq_state;
    logic [15:0]          drop_count;
    logic [NUM_LANES-1:0] lane_drop_mask;
    modport master (
        input  gt_pll_lock, lane_aligned,
        output gt_sys_reset, link_up, user_rstn, link_fail, retry_count, seq_state,
        output drop_count, lane_drop_mask
    );
    modport slave (
        output gt_pll_lock, lane_aligned,
        input  gt_sys_reset, link_up, user_rstn, link_fail, retry_count, seq_state,
        input  drop_count, lane_drop_mask
    );
endinterface

// File: rtl/gt_link_bringup_seq.sv
// gt_link_bringup_seq: N-lane GT reset/lock/align/debounce sequencer with bounded retries.
// Define GT_LINK_SEQ_STATS_EN to build the link-drop counter and sticky lane-drop mask.
module gt_link_bringup_seq #(
    parameter int NUM_LANES         = 4,
    parameter int RESET_HOLD_CYCLES = 64,
    parameter int LOCK_TIMEOUT      = 65536,
    parameter int ALIGN_TIMEOUT     = 131072,
    parameter int DEBOUNCE_CYCLES   = 256,
    parameter int MAX_RETRIES       = 8
) (
    input logic                     CLK,
    input logic                     rstn,
    gt_link_bringup_seq_if.master   bus
);
    localparam int TMAX0 = LOCK_TIMEOUT > ALIGN_TIMEOUT ? LOCK_TIMEOUT : ALIGN_TIMEOUT;
    localparam int TMAX  = TMAX0 > RESET_HOLD_CYCLES ? TMAX0 : RESET_HOLD_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int DW    = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_RESET      = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_WAIT_ALIGN = 3'd2,
        S_DEBOUNCE   = 3'd3,
        S_LINK_UP    = 3'd4,
        S_FAILED     = 3'd5
    } state_t;

    logic                 lock_s1_q, lock_s2_q;
    logic [NUM_LANES-1:0] lanes_s1_q, lanes_s2_q;
    state_t               state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        deb_q, deb_d;
    logic [7:0]           retry_q, retry_d;
    logic                 gt_sys_reset_q, gt_sys_reset_d;
    logic                 link_up_q, link_up_d;
    logic                 user_rstn_q, user_rstn_d;
    logic                 link_fail_q, link_fail_d;
    logic                 retry, all_lanes, keep_cnt;

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            lock_s1_q  <= 1'b0;
            lock_s2_q  <= 1'b0;
            lanes_s1_q <= '0;
            lanes_s2_q <= '0;
        end else begin
            lock_s1_q  <= bus.gt_pll_lock;
            lock_s2_q  <= lock_s1_q;
            lanes_s1_q <= bus.lane_aligned;
            lanes_s2_q <= lanes_s1_q;
        end
    end

    assign all_lanes = &lanes_s2_q;

    always_comb begin
        state_d = state_q;
        retry   = 1'b0;
        case (state_q)
            S_RESET:      state_d = int'(cnt_q) >= RESET_HOLD_CYCLES - 1 ? S_WAIT_LOCK : S_RESET;
            S_WAIT_LOCK:  if (lock_s2_q) state_d = S_WAIT_ALIGN;
                          else retry = int'(cnt_q) >= LOCK_TIMEOUT - 1;
            S_WAIT_ALIGN: if (!lock_s2_q) retry = 1'b1;
                          else if (all_lanes) state_d = S_DEBOUNCE;
                          else retry = int'(cnt_q) >= ALIGN_TIMEOUT - 1;
            S_DEBOUNCE:   if (!lock_s2_q) retry = 1'b1;
                          else if (!all_lanes) state_d = S_WAIT_ALIGN;
                          else if (int'(deb_q) >= DEBOUNCE_CYCLES - 1) state_d = S_LINK_UP;
            S_LINK_UP:    if (!lock_s2_q || !all_lanes) state_d = S_RESET;
            default:      state_d = S_FAILED;
        endcase
        retry_d = retry && retry_q != 8'hFF ? retry_q + 8'd1 : retry_q;
        if (retry)
            state_d = MAX_RETRIES != 0 && int'(retry_d) == MAX_RETRIES ? S_FAILED : S_RESET;
        // The align timer spans WAIT_ALIGN and DEBOUNCE so lane bouncing cannot extend it
        keep_cnt = state_d == state_q
                || (state_q == S_WAIT_ALIGN && state_d == S_DEBOUNCE)
                || (state_q == S_DEBOUNCE && state_d == S_WAIT_ALIGN);
        cnt_d = !keep_cnt ? '0 : cnt_q == '1 ? cnt_q : cnt_q + TW'(1);
        deb_d = state_q == S_DEBOUNCE && state_d == S_DEBOUNCE ? deb_q + DW'(1) : '0;
        gt_sys_reset_d = state_d == S_RESET || state_d == S_FAILED;
        link_up_d      = state_q == S_LINK_UP && state_d == S_LINK_UP;
        user_rstn_d    = link_up_d;
        link_fail_d    = state_d == S_FAILED;
    end

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_RESET;
            cnt_q          <= '0;
            deb_q          <= '0;
            retry_q        <= '0;
            gt_sys_reset_q <= 1'b1;
            link_up_q      <= 1'b0;
            user_rstn_q    <= 1'b0;
            link_fail_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            deb_q          <= deb_d;
            retry_q        <= retry_d;
            gt_sys_reset_q <= gt_sys_reset_d;
            link_up_q      <= link_up_d;
            user_rstn_q    <= user_rstn_d;
            link_fail_q    <= link_fail_d;
        end
    end

    assign bus.gt_sys_reset = gt_sys_reset_q;
    assign bus.link_up      = link_up_q;
    assign bus.user_rstn    = user_rstn_q;
    assign bus.link_fail    = link_fail_q;
    assign bus.retry_count  = retry_q;
    assign bus.seq_state    = state_q;

`ifdef GT_LINK_SEQ_STATS_EN
    logic [15:0]          drop_q, drop_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;

    always_comb begin
        drop_d = drop_q;
        mask_d = mask_q;
        if (state_q == S_LINK_UP && state_d == S_RESET) begin
            drop_d = drop_q == 16'hFFFF ? drop_q : drop_q + 16'd1;
            mask_d = mask_q | ~lanes_s2_q;
        end
    end

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            drop_q <= '0;
            mask_q <= '0;
        end else begin
            drop_q <= drop_d;
            mask_q <= mask_d;
        end
    end

    assign bus.drop_count     = drop_q;
    assign bus.lane_drop_mask = mask_q;
`else
    assign bus.drop_count     = '0;
    assign bus.lane_drop_mask = '0;
`endif
endmodule

// File: tb/tb_gt_link_bringup_seq.sv
// tb_gt_link_bringup_seq: directed checks of bring-up, timeouts, glitches, drops and resets.
module tb_gt_link_bringup_seq;
    logic CLK = 1'b0;
    logic rstn, rstn2;
    int   total = 0, passed = 0, failed = 0;

    gt_link_bringup_seq_if #(.NUM_LANES(4)) bus0 ();
    gt_link_bringup_seq_if #(.NUM_LANES(4)) bus1 ();

    gt_link_bringup_seq #(
        .NUM_LANES(4), .RESET_HOLD_CYCLES(4), .LOCK_TIMEOUT(16), .ALIGN_TIMEOUT(32),
        .DEBOUNCE_CYCLES(8), .MAX_RETRIES(2)
    ) u0 (.CLK(CLK), .rstn(rstn), .bus(bus0));

    gt_link_bringup_seq #(
        .NUM_LANES(4), .RESET_HOLD_CYCLES(4), .LOCK_TIMEOUT(16), .ALIGN_TIMEOUT(32),
        .DEBOUNCE_CYCLES(8), .MAX_RETRIES(0)
    ) u1 (.CLK(CLK), .rstn(rstn2), .bus(bus1));

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef GT_LINK_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    initial begin
        rstn = 1'b0;
        rstn2 = 1'b0;
        bus0.gt_pll_lock = 1'b1;
        bus0.lane_aligned = 4'hF;
        bus1.gt_pll_lock = 1'b0;
        bus1.lane_aligned = 4'h0;
        step(3);
        chk("rst_state", 32'(bus0.seq_state), 0);
        chk("rst_gtrst", 32'(bus0.gt_sys_reset), 1);
        chk("rst_linkup", 32'(bus0.link_up), 0);
        chk("rst_urstn", 32'(bus0.user_rstn), 0);
        chk("rst_fail", 32'(bus0.link_fail), 0);
        chk("rst_retry", 32'(bus0.retry_count), 0);
        chk("rst_drop", 32'(bus0.drop_count), 0);
        chk("rst_mask", 32'(bus0.lane_drop_mask), 0);

        rstn = 1'b1;
        step(3);
        chk("nom_hold_state", 32'(bus0.seq_state), 0);
        chk("nom_hold_gtrst", 32'(bus0.gt_sys_reset), 1);
        step(1);
        chk("nom_waitlock", 32'(bus0.seq_state), 1);
        chk("nom_gtrst_off", 32'(bus0.gt_sys_reset), 0);
        step(1);
        chk("nom_waitalign", 32'(bus0.seq_state), 2);
        step(1);
        chk("nom_debounce", 32'(bus0.seq_state), 3);
        step(7);
        chk("nom_debounce_end", 32'(bus0.seq_state), 3);
        step(1);
        chk("nom_linkup_state", 32'(bus0.seq_state), 4);
        chk("nom_linkup_lag", 32'(bus0.link_up), 0);
        chk("nom_urstn_lag", 32'(bus0.user_rstn), 0);
        step(1);
        chk("nom_linkup", 32'(bus0.link_up), 1);
        chk("nom_urstn", 32'(bus0.user_rstn), 1);
        chk("nom_retry", 32'(bus0.retry_count), 0);

        bus0.lane_aligned = 4'hB;
        step(2);
        chk("drop_sync_state", 32'(bus0.seq_state), 4);
        chk("drop_sync_linkup", 32'(bus0.link_up), 1);
        step(1);
        chk("drop_state", 32'(bus0.seq_state), 0);
        chk("drop_linkup", 32'(bus0.link_up), 0);
        chk("drop_urstn", 32'(bus0.user_rstn), 0);
        chk("drop_gtrst", 32'(bus0.gt_sys_reset), 1);
        chk("drop_retry", 32'(bus0.retry_count), 0);
        chk("drop_count", 32'(bus0.drop_count), STATS ? 1 : 0);
        chk("drop_mask", 32'(bus0.lane_drop_mask), STATS ? 4 : 0);

        bus0.lane_aligned = 4'hF;
        step(8);
        chk("glitch_deb", 32'(bus0.seq_state), 3);
        step(1);
        bus0.lane_aligned = 4'hB;
        step(1);
        bus0.lane_aligned = 4'hF;
        step(1);
        chk("glitch_deb5", 32'(bus0.seq_state), 3);
        step(1);
        chk("glitch_back_align", 32'(bus0.seq_state), 2);
        chk("glitch_retry", 32'(bus0.retry_count), 0);
        step(1);
        chk("glitch_redeb", 32'(bus0.seq_state), 3);
        step(7);
        chk("glitch_full_deb", 32'(bus0.seq_state), 3);
        step(1);
        chk("glitch_linkup_state", 32'(bus0.seq_state), 4);
        step(1);
        chk("glitch_linkup", 32'(bus0.link_up), 1);

        bus0.gt_pll_lock = 1'b0;
        step(3);
        chk("lockdrop_state", 32'(bus0.seq_state), 0);
        chk("lockdrop_retry", 32'(bus0.retry_count), 0);
        chk("lockdrop_count", 32'(bus0.drop_count), STATS ? 2 : 0);
        chk("lockdrop_mask", 32'(bus0.lane_drop_mask), STATS ? 4 : 0);
        step(19);
        chk("to1_waitlock", 32'(bus0.seq_state), 1);
        chk("to1_retry_pre", 32'(bus0.retry_count), 0);
        step(1);
        chk("to1_state", 32'(bus0.seq_state), 0);
        chk("to1_retry", 32'(bus0.retry_count), 1);
        chk("to1_gtrst", 32'(bus0.gt_sys_reset), 1);
        step(19);
        chk("to2_waitlock", 32'(bus0.seq_state), 1);
        chk("to2_gtrst_off", 32'(bus0.gt_sys_reset), 0);
        step(1);
        chk("fail_state", 32'(bus0.seq_state), 5);
        chk("fail_flag", 32'(bus0.link_fail), 1);
        chk("fail_gtrst", 32'(bus0.gt_sys_reset), 1);
        chk("fail_retry", 32'(bus0.retry_count), 2);
        chk("fail_linkup", 32'(bus0.link_up), 0);
        step(10);
        chk("fail_terminal", 32'(bus0.seq_state), 5);

        rstn = 1'b0;
        #1;
        chk("arst_state", 32'(bus0.seq_state), 0);
        chk("arst_fail", 32'(bus0.link_fail), 0);
        chk("arst_retry", 32'(bus0.retry_count), 0);
        chk("arst_gtrst", 32'(bus0.gt_sys_reset), 1);
        chk("arst_drop", 32'(bus0.drop_count), 0);
        chk("arst_mask", 32'(bus0.lane_drop_mask), 0);
        bus0.gt_pll_lock = 1'b1;
        step(1);
        rstn = 1'b1;
        step(8);
        chk("mid_deb_state", 32'(bus0.seq_state), 3);
        rstn = 1'b0;
        #1;
        chk("mid_arst_state", 32'(bus0.seq_state), 0);
        chk("mid_arst_gtrst", 32'(bus0.gt_sys_reset), 1);
        chk("mid_arst_linkup", 32'(bus0.link_up), 0);
        chk("mid_arst_urstn", 32'(bus0.user_rstn), 0);
        step(1);
        rstn = 1'b1;
        step(3);
        chk("restart_hold", 32'(bus0.seq_state), 0);
        step(1);
        chk("restart_waitlock", 32'(bus0.seq_state), 1);
        step(10);
        chk("restart_linkup_state", 32'(bus0.seq_state), 4);
        step(1);
        chk("restart_linkup", 32'(bus0.link_up), 1);
        chk("restart_urstn", 32'(bus0.user_rstn), 1);

        rstn2 = 1'b1;
        step(20);
        chk("inf_first_retry", 32'(bus1.retry_count), 1);
        chk("inf_first_state", 32'(bus1.seq_state), 0);
        step(5990);
        chk("inf_retry_sat", 32'(bus1.retry_count), 255);
        chk("inf_no_fail", 32'(bus1.link_fail), 0);
        chk("inf_not_failed", 32'(bus1.seq_state == 3'd5), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
